// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default sizing for the pipeline sequencer
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_HALT_DRAIN = 3;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: wrap-around event counter with synchronous active-low clear
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= !rst_n ? '0 : inc ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush/enable control plus halt-drain-resume FSM and perf counters
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int HALT_DRAIN = DEF_HALT_DRAIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             redirect,
  input  logic             halt_req,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);
  localparam int DW = HALT_DRAIN > 1 ? $clog2(HALT_DRAIN) : 1;
  state_t st, nst;
  logic [DW-1:0] dcnt, ndcnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st   <= RUN;
      dcnt <= '0;
    end else begin
      st   <= nst;
      dcnt <= ndcnt;
    end
  end
  // DRAIN/HALT share the frozen-front-end outputs set by these defaults
  always_comb begin
    nst        = st;
    ndcnt      = dcnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b1;
    if (st == RUN) begin
      if (redirect) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
      end else if (!load_use_stall) begin
        idex_flush = 1'b0;
        pc_en      = !halt_req;
        ifid_en    = !halt_req;
        nst        = halt_req ? DRAIN : RUN;
        ndcnt      = halt_req ? DW'(HALT_DRAIN - 1) : dcnt;
      end
    end else if (st == DRAIN) begin
      nst   = dcnt == '0 ? HALT : DRAIN;
      ndcnt = dcnt == '0 ? dcnt : dcnt - 1'b1;
    end else begin
      nst = go ? RUN : st;
    end
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end
  assign halted = rst_n && st == HALT;
  assign state  = st;
  perf_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .rst_n(rst_n), .inc(st == RUN || st == DRAIN), .cnt(cycle_cnt)
  );
  perf_counter #(.CNT_W(CNT_W)) u_stl (
    .clk(clk), .rst_n(rst_n), .inc(st == RUN && load_use_stall && !redirect), .cnt(stall_cnt)
  );
  perf_counter #(.CNT_W(CNT_W)) u_red (
    .clk(clk), .rst_n(rst_n), .inc(st == RUN && redirect), .cnt(redirect_cnt)
  );
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed vectors queued into a scoreboard, checked by a negedge monitor
module tb_pipeline_sequencer;
  localparam int CW = 4;
  localparam logic [4:0] RUNN = 5'b11000;
  localparam logic [4:0] RED  = 5'b11110;
  localparam logic [4:0] STL  = 5'b00010;
  localparam logic [4:0] HRQ  = 5'b00000;
  localparam logic [4:0] DRN  = 5'b00010;
  localparam logic [4:0] HLT  = 5'b00011;
  localparam logic [4:0] RST  = 5'b00110;
  typedef struct {
    logic [4:0] c;
    int st, cc, sc, rc, id;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, load_use_stall = 1'b0, redirect = 1'b0, halt_req = 1'b0, go = 1'b0;
  logic pc_en, ifid_en, ifid_flush, idex_flush, halted;
  logic [1:0] state;
  logic [CW-1:0] cycle_cnt, stall_cnt, redirect_cnt;
  exp_t q[$];
  exp_t m_e;
  int total = 0, passed = 0, nstep = 0;
  pipeline_sequencer #(.CNT_W(CW), .HALT_DRAIN(3)) dut (
    .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall), .redirect(redirect),
    .halt_req(halt_req), .go(go), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted), .state(state), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst_n && state == 2'd1) assert (!redirect) else $error("redirect during DRAIN");
  task automatic check(input string n, input int id, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s step %0d: got %0d expected %0d", n, id, a, e);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      check("ctrl{pc,ifid,iff,idf,halted}", m_e.id, int'({pc_en, ifid_en, ifid_flush, idex_flush, halted}), int'(m_e.c));
      if (m_e.st >= 0) check("state", m_e.id, int'(state), m_e.st);
      if (m_e.cc >= 0) check("cycle_cnt", m_e.id, int'(cycle_cnt), m_e.cc);
      if (m_e.sc >= 0) check("stall_cnt", m_e.id, int'(stall_cnt), m_e.sc);
      if (m_e.rc >= 0) check("redirect_cnt", m_e.id, int'(redirect_cnt), m_e.rc);
    end
  end
  task automatic step(input logic r, lu, rd, hr, g, input logic [4:0] c,
                      input int st = -1, input int cc = -1, input int sc = -1, input int rc = -1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; load_use_stall = lu; redirect = rd; halt_req = hr; go = g;
    e.c = c; e.st = st; e.cc = cc; e.sc = sc; e.rc = rc; e.id = nstep++;
    q.push_back(e);
  endtask
  initial begin
    step(0, 0, 0, 0, 0, RST);
    step(0, 0, 0, 0, 0, RST, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, RUNN, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, STL, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, STL, 0, 2, 1, 0);
    step(1, 0, 0, 0, 0, RUNN, 0, 3, 2, 0);
    step(1, 1, 1, 0, 0, RED, 0, 4, 2, 0);
    step(1, 0, 1, 1, 0, RED, 0, 5, 2, 1);
    step(1, 0, 0, 0, 0, RUNN, 0, 6, 2, 2);
    step(1, 0, 0, 1, 0, HRQ, 0, 7, 2, 2);
    step(1, 1, 0, 0, 1, DRN, 1, 8, 2, 2);
    step(1, 0, 0, 1, 0, DRN, 1, 9, 2, 2);
    step(1, 0, 0, 0, 0, DRN, 1, 10, 2, 2);
    step(1, 0, 0, 0, 0, HLT, 2, 11, 2, 2);
    step(1, 1, 0, 1, 0, HLT, 2, 11, 2, 2);
    step(1, 0, 0, 1, 1, HLT, 2, 11, 2, 2);
    step(1, 0, 0, 0, 0, RUNN, 0, 11, 2, 2);
    step(1, 0, 0, 1, 0, HRQ, 0, 12, 2, 2);
    step(1, 0, 0, 0, 0, DRN, 1, 13, 2, 2);
    step(0, 0, 0, 0, 0, RST, 1, 14, 2, 2);
    step(1, 0, 0, 0, 0, RUNN, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, RUNN, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 1, 0, 0, RED, 0, (2 + i) % 16, 0, i);
    step(1, 0, 1, 0, 0, RED, 0, 1, 0, 15);
    step(1, 0, 0, 0, 0, RUNN, 0, 2, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central pipeline control for the five-stage redirect pipeline. Consumes the hazard unit's load-use stall, the EX-stage branch/jump redirect and the ID-stage halt request (syscall with $v0 == 10). Drives the PC and IF/ID enables and the IF/ID and ID/EX flushes, and runs the halt/drain/resume state machine. Keeps wrap-around performance counters for cycles, stall bubbles and redirects.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter
- HALT_DRAIN, 3, number of DRAIN cycles before HALT (legal range ≥ 1)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; synchronous, active-low
- load_use_stall  in  1  load-use hazard from the hazard unit (instruction in ID depends on a load in EX)
- redirect  in  1  branch/jump taken, resolved in EX; PC mux selects the target this cycle
- halt_req  in  1  halting syscall present in ID
- go  in  1  resume request, honoured only in HALT
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID clear to NOP (applies at the next edge)
- idex_flush  out  1  ID/EX clear to NOP (inserts a bubble)
- halted  out  1  high while in HALT
- state  out  2  current state code: RUN=0, DRAIN=1, HALT=2
- cycle_cnt  out  CNT_W  non-HALT cycle count
- stall_cnt  out  CNT_W  count of load-use bubbles inserted
- redirect_cnt  out  CNT_W  count of redirects taken

## Operation
- State, drain counter and perf counters are registered. Control outputs (pc_en, ifid_en, ifid_flush, idex_flush) are combinational from state and inputs.
- rst_n low at an edge: next state RUN, drain counter 0, all perf counters 0.
- While rst_n is low, force outputs: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, halted=0.
- RUN, input priority: redirect > load_use_stall > halt_req.
  - redirect: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; redirect_cnt+1. Load-use and halt in the same cycle are ignored, because the ID instruction is killed.
  - load_use_stall: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1; stall_cnt+1.
  - halt_req: pc_en=0, ifid_en=0, idex_flush=0, so the syscall advances. Next state DRAIN, drain counter loads HALT_DRAIN-1.
  - none: pc_en=1, ifid_en=1, both flushes 0.
- DRAIN: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1.
  - Drain counter decrements each cycle; when it is 0, next state HALT.
  - redirect, load_use_stall and halt_req are ignored. A redirect here is a protocol error and the bench asserts on it.
- HALT: halted=1, outputs as in DRAIN. go=1 → next state RUN. IF/ID still holds the post-syscall instruction, which resumes.
- go outside HALT is ignored. halt_req in HALT is ignored; go wins.
- Counters: +1 modulo 2^CNT_W (wrap, no saturation).
  - cycle_cnt increments in RUN and DRAIN.
  - A reset edge overrides any increment in that cycle.

## Timing
- Control outputs: zero latency, same cycle as the inputs. Counter updates are visible after the next edge.
- Halt: with halt_req accepted in cycle t, DRAIN spans t+1 .. t+HALT_DRAIN and halted=1 from cycle t+HALT_DRAIN+1.
- Resume: go at cycle h → RUN at h+1, with pc_en=1 in h+1.
- Back-to-back load_use_stall for N cycles → N bubbles and stall_cnt += N.
- Reset mid-DRAIN or mid-HALT → RUN after the edge. The drain is abandoned and halted drops in the same cycle that rst_n is sampled low.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN/DRAIN/HALT, 2-bit codes as above)
  - default constants for CNT_W and HALT_DRAIN
- Sub-module perf_counter (CNT_W, sync active-low clear, inc enable, wrap), instantiated three times.
- The FSM, drain counter and output decode live in the top module.

## Test plan
- Reset with all inputs 0 → during reset pc_en=0, ifid_flush=1, idex_flush=1. After release, pc_en=1, ifid_en=1, flushes 0, all counters 0, state=0.
- load_use_stall high for 2 cycles → pc_en=0, ifid_en=0, idex_flush=1 for exactly 2 cycles; stall_cnt=2; cycle_cnt advances 2.
- redirect and load_use_stall in the same cycle → pc_en=1, both flushes 1; redirect_cnt=1, stall_cnt unchanged.
- halt_req in cycle 10 with HALT_DRAIN=3 → state=1 in cycles 11–13, halted=1 from cycle 14, cycle_cnt frozen. go in cycle 20 → state=0 and pc_en=1 in cycle 21.
- rst_n low in the second DRAIN cycle → state=0, counters 0, halted never asserts.
- CNT_W=4, preload via 15 redirects then one more → redirect_cnt wraps from 15 to 0.
